// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined chunked adder.
package pipe_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH  = 16;
    localparam int unsigned DEFAULT_STAGES = 4;

    // Bits handled by each pipeline stage; a zero stage count is guarded by the top.
    function automatic int unsigned chunk_width(input int unsigned width, input int unsigned stages);
        return (stages == 0) ? width : width / stages;
    endfunction

    // One operand beat as presented on the input side.
    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] a;
        logic [DEFAULT_WIDTH-1:0] b;
        logic                     cin;
        logic                     sub;
    } beat_t;

endpackage

// File: rtl/adder_chunk.sv
// Combinational CW-bit full adder with carry-in and carry-out.
module adder_chunk #(
    parameter int unsigned CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] s,
    output logic          cout
);

    logic [CW:0] total;

    // Widen before adding so the carry lands in the top bit.
    assign total = (CW+1)'(a) + (CW+1)'(b) + (CW+1)'(cin);
    assign s     = total[CW-1:0];
    assign cout  = total[CW];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder, one CW-bit chunk per stage, valid/ready on both sides.
// Optional macro PIPE_ADDER_SUB_EN adds a 'sub' input: a - b - cin as a + ~b + !cin.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = chunk_width(WIDTH, STAGES);

    // Reject configurations that cannot be split into equal chunks.
    if (STAGES == 0) begin : g_bad_stages
        $error("pipe_adder: STAGES must be at least 1");
    end else if ((WIDTH % STAGES) != 0) begin : g_bad_width
        $error("pipe_adder: WIDTH must be a multiple of STAGES");
    end

    // Per-stage source view: index 0 is the input port, index k is stage k-1.
    logic [WIDTH-1:0] src_a     [STAGES];
    logic [WIDTH-1:0] src_b     [STAGES];
    logic [WIDTH-1:0] src_sum   [STAGES];
    logic             src_c     [STAGES];
    logic             src_valid [STAGES];
    logic             src_inv   [STAGES];

    logic [STAGES-1:0] vld;
    logic [STAGES:0]   adv;

    assign src_a[0]     = a;
    assign src_b[0]     = b;
    assign src_sum[0]   = '0;
    assign src_valid[0] = in_valid;
`ifdef PIPE_ADDER_SUB_EN
    assign src_inv[0]   = sub;
    assign src_c[0]     = cin ^ sub;
`else
    assign src_inv[0]   = 1'b0;
    assign src_c[0]     = cin;
`endif

    // Advance chain: a stage may load when it is empty or its contents move on.
    always_comb begin
        adv         = '0;
        adv[STAGES] = out_ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            adv[k] = !vld[k] || adv[k+1];
        end
    end

    assign in_ready = adv[0];

    for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
        logic             valid_q, valid_d;
        logic             carry_q, carry_d;
        logic [WIDTH-1:0] sum_q, sum_d;
        logic [CW-1:0]    b_chunk;
        logic [CW-1:0]    s_c;
        logic             co_c;

        assign b_chunk = src_b[k][CW-1:0] ^ {CW{src_inv[k]}};

        adder_chunk #(.CW(CW)) u_chunk (
            .a    (src_a[k][CW-1:0]),
            .b    (b_chunk),
            .cin  (src_c[k]),
            .s    (s_c),
            .cout (co_c)
        );

        // Load the next beat and shift the new sum chunk in from the top.
        always_comb begin
            valid_d = valid_q;
            carry_d = carry_q;
            sum_d   = sum_q;
            if (adv[k]) begin
                valid_d = src_valid[k];
                carry_d = co_c;
                sum_d   = WIDTH'({s_c, src_sum[k]} >> CW);
            end
        end

        // Stage state register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else begin
                valid_q <= valid_d;
                carry_q <= carry_d;
                sum_q   <= sum_d;
            end
        end

        assign vld[k] = valid_q;

        if (k == int'(STAGES) - 1) begin : g_last
            assign out_valid = valid_q;
            assign sum       = sum_q;
            assign cout      = carry_q;
        end else begin : g_fwd
            logic [WIDTH-1:0] a_q, a_d;
            logic [WIDTH-1:0] b_q, b_d;
`ifdef PIPE_ADDER_SUB_EN
            logic             inv_q, inv_d;
`endif

            // Pending operand chunks move down so the next chunk sits at bit 0.
            always_comb begin
                a_d = a_q;
                b_d = b_q;
`ifdef PIPE_ADDER_SUB_EN
                inv_d = inv_q;
`endif
                if (adv[k]) begin
                    a_d = src_a[k] >> CW;
                    b_d = src_b[k] >> CW;
`ifdef PIPE_ADDER_SUB_EN
                    inv_d = src_inv[k];
`endif
                end
            end

            // Pending operand register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
`ifdef PIPE_ADDER_SUB_EN
                    inv_q <= 1'b0;
`endif
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
`ifdef PIPE_ADDER_SUB_EN
                    inv_q <= inv_d;
`endif
                end
            end

            assign src_a[k+1]     = a_q;
            assign src_b[k+1]     = b_q;
            assign src_sum[k+1]   = sum_q;
            assign src_c[k+1]     = carry_q;
            assign src_valid[k+1] = valid_q;
`ifdef PIPE_ADDER_SUB_EN
            assign src_inv[k+1]   = inv_q;
`else
            assign src_inv[k+1]   = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder (WIDTH=16, STAGES=4) with a behavioural model.
module tb_pipe_adder;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned STAGES = 4;
`ifdef PIPE_ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             sub_drv = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;

    pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef PIPE_ADDER_SUB_EN
        .sub       (sub_drv),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int acc_count = 0;

    typedef struct {
        logic [WIDTH:0] res;
        int             t_acc;
    } exp_t;

    typedef struct {
        logic [WIDTH:0] res;
        int             lat;
    } emit_t;

    exp_t  exp_q[$];
    emit_t emit_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: {cout,sum} from plain arithmetic on the operands.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic c, input logic s);
        logic [WIDTH:0] r;
        if (s && SUB_EN) r = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(!c);
        else             r = {1'b0, x} + {1'b0, y}  + (WIDTH+1)'(c);
        return r;
    endfunction

    // Compare process: inputs and outputs are settled at the falling edge.
    always @(negedge clk) begin
        logic exp_ov;
        if (!rst_n) begin
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_sum", 32'(sum), 32'd0);
            check("rst_cout", 32'(cout), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd1);
            exp_q.delete();
        end else begin
            check("in_ready", 32'(in_ready), 32'((exp_q.size() < STAGES) || out_ready));
            exp_ov = (exp_q.size() > 0) && (cyc + 1 - exp_q[0].t_acc >= int'(STAGES));
            check("out_valid", 32'(out_valid), 32'(exp_ov));
            if (exp_ov) begin
                check("sum", 32'(sum), 32'(exp_q[0].res[WIDTH-1:0]));
                check("cout", 32'(cout), 32'(exp_q[0].res[WIDTH]));
                if (out_ready) begin
                    emit_q.push_back('{res: exp_q[0].res, lat: cyc + 1 - exp_q[0].t_acc});
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back('{res: model(a, b, cin, sub_drv), t_acc: cyc + 1});
                acc_count++;
            end
        end
    end

    // Present one beat and hold it until accepted, bounded.
    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic c, input logic s);
        logic got;
        int   n;
        in_valid = 1'b1;
        a = x; b = y; cin = c; sub_drv = s;
        n = 0;
        do begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!got && n < 300);
        if (!got) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            idle(1);
            n++;
        end
        idle(1);
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic expect_emit(input string name, input int idx, input logic [WIDTH:0] res, input int lat);
        if (idx >= emit_q.size()) begin
            check({name, "_missing"}, 32'(emit_q.size()), 32'(idx + 1));
        end else begin
            check({name, "_res"}, 32'(emit_q[idx].res), 32'(res));
            check({name, "_lat"}, 32'(emit_q[idx].lat), 32'(lat));
        end
    endtask

    initial begin
        int base;
        bit rnd_run;

        // Reset held, then released: bench stays idle.
        #1 rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(3);
        check("idle_out_valid", 32'(out_valid), 32'd0);

        // Single beats across chunk boundaries and the MSB wrap.
        out_ready = 1'b1;
        emit_q.delete();
        send(16'h00FF, 16'h0001, 1'b0, 1'b0);
        drain();
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        drain();
        expect_emit("ripple", 0, 17'h00100, 4);
        expect_emit("wrap", 1, 17'h10000, 4);

        // Back-to-back stream at full rate.
        emit_q.delete();
        send(16'h1234, 16'h4321, 1'b0, 1'b0);
        send(16'h8000, 16'h8000, 1'b1, 1'b0);
        send(16'hAAAA, 16'h5555, 1'b1, 1'b0);
        drain();
        expect_emit("stream0", 0, 17'h05555, 4);
        expect_emit("stream1", 1, 17'h10001, 4);
        expect_emit("stream2", 2, 17'h10000, 4);

        // Backpressure: six beats offered while the consumer is stalled.
        emit_q.delete();
        out_ready = 1'b0;
        base = acc_count;
        fork
            begin
                for (int i = 0; i < 6; i++) send(16'(16'h1000 * i + 16'h0F0F), 16'(i), 1'b1, 1'b0);
            end
            begin
                idle(10);
                check("bp_accepted", 32'(acc_count - base), 32'd4);
                check("bp_in_ready", 32'(in_ready), 32'd0);
                check("bp_sum_held", 32'(sum), 32'h0F10);
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", 32'(emit_q.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            expect_emit("bp_order", i, {1'b0, 16'(16'h1000 * i + 16'h0F0F + i + 1)}, emit_q.size() > i ? emit_q[i].lat : 0);

        // Reset mid-flight discards in-flight beats asynchronously.
        emit_q.delete();
        out_ready = 1'b0;
        send(16'h0101, 16'h0202, 1'b0, 1'b0);
        send(16'h0303, 16'h0404, 1'b0, 1'b0);
        send(16'h0505, 16'h0606, 1'b0, 1'b0);
        idle(4);
        check("mid_out_valid_before", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_out_valid_async", 32'(out_valid), 32'd0);
        idle(1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(10);
        check("mid_no_ghosts", 32'(emit_q.size()), 32'd0);

`ifdef PIPE_ADDER_SUB_EN
        // Subtraction: borrow shows as cout=0.
        emit_q.delete();
        send(16'h0005, 16'h0007, 1'b0, 1'b1);
        send(16'h0007, 16'h0005, 1'b0, 1'b1);
        send(16'h0007, 16'h0005, 1'b0, 1'b0);
        drain();
        expect_emit("sub_borrow", 0, 17'h0FFFE, 4);
        expect_emit("sub_noborrow", 1, 17'h10002, 4);
        expect_emit("sub_off", 2, 17'h0000C, 4);
`endif

        // Randomised traffic with random consumer stalls.
        rnd_run = 1'b1;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                end
                rnd_run = 1'b0;
            end
            begin
                while (rnd_run) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    idle(1);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
